// File: rtl/spi_master_core_if.sv
// Register-strobe bus between the AXI-Lite register slave and the SPI core.
// master : the register slave (drives addresses, data and strobes)
// slave  : the SPI core (returns combinational read data)
//   WDATA_I  write data            WADDR_I  write byte address
//   WENA_I   one-cycle write strobe
//   RADDR_I  read byte address     RENA_I   one-cycle read strobe
//   RDATA_O  read data for RADDR_I
interface spi_master_core_if #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 4
);
    logic [C_AXI_DATA_WIDTH-1:0] WDATA_I;
    logic [C_AXI_ADDR_WIDTH-1:0] WADDR_I;
    logic                        WENA_I;
    logic [C_AXI_ADDR_WIDTH-1:0] RADDR_I;
    logic                        RENA_I;
    logic [C_AXI_DATA_WIDTH-1:0] RDATA_O;

    modport master (
        output WDATA_I, WADDR_I, WENA_I, RADDR_I, RENA_I,
        input  RDATA_O
    );

    modport slave (
        input  WDATA_I, WADDR_I, WENA_I, RADDR_I, RENA_I,
        output RDATA_O
    );
endinterface

// File: rtl/spi_master_core.sv
// Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Ports:
//   AXI_ACLK     core clock, rising edge
//   AXI_ARESETN  asynchronous active-low reset
//   bus          register strobe bus (slave modport)
//   MOSI/MISO    serial data out / in
//   SCLK         serial clock, idle low
//   CSn          chip select, active low
//   INT          level interrupt = CTRL.IE & STATUS.DONE
// Registers (ADDR[3:2]):
//   0x0 CTRL    [0] IE, [15:8] CLKDIV
//   0x4 TXDATA  write starts a transfer when idle, reads 0
//   0x8 RXDATA  last received byte; read with RENA clears DONE
//   0xC STATUS  [0] BUSY, [1] DONE (W1C), [2] OVR (W1C)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | CSn high, waiting for a TXDATA write
// ST_LEAD  | CSn low, SCLK low for one half period before the first rise
// ST_SHIFT | 16 half periods: sample MISO on rises, update MOSI on falls
// ST_TRAIL | CSn still low, SCLK low for one half period after last fall
module spi_master_core #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 4
) (
    input  logic             AXI_ACLK,
    input  logic             AXI_ARESETN,
    spi_master_core_if.slave bus,
    output logic             MOSI,
    input  logic             MISO,
    output logic             SCLK,
    output logic             CSn,
    output logic             INT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL
    } state_t;

    state_t state;

    logic [C_AXI_DATA_WIDTH-1:0] wdata;
    logic [C_AXI_ADDR_WIDTH-1:0] waddr;
    logic [C_AXI_ADDR_WIDTH-1:0] raddr;

    logic       ie;
    logic [7:0] clkdiv;
    logic [7:0] clkdiv_lat;
    logic [7:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] rxdata;
    logic       busy;
    logic       done;
    logic       ovr;

    logic       wr_ctrl;
    logic       wr_tx;
    logic       wr_stat;
    logic       rd_rx;
    logic [15:0] rd_word;

    // Only ADDR[3:2] and DATA[15:0] carry meaning.
    logic unused_bus_bits;

    assign wdata = bus.WDATA_I;
    assign waddr = bus.WADDR_I;
    assign raddr = bus.RADDR_I;

    assign unused_bus_bits = ^{wdata, waddr, raddr};

    assign wr_ctrl = bus.WENA_I && (waddr[3:2] == 2'd0);
    assign wr_tx   = bus.WENA_I && (waddr[3:2] == 2'd1);
    assign wr_stat = bus.WENA_I && (waddr[3:2] == 2'd3);
    assign rd_rx   = bus.RENA_I && (raddr[3:2] == 2'd2);

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state      <= ST_IDLE;
            ie         <= 1'b0;
            clkdiv     <= 8'd0;
            clkdiv_lat <= 8'd0;
            cnt        <= 8'd0;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            rxdata     <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovr        <= 1'b0;
            MOSI       <= 1'b0;
            SCLK       <= 1'b0;
            CSn        <= 1'b1;
        end else begin
            if (wr_ctrl) begin
                ie     <= wdata[0];
                clkdiv <= wdata[15:8];
            end

            // Clears come first so that a set later in this block wins.
            if (rd_rx || (wr_stat && wdata[1])) begin
                done <= 1'b0;
            end
            if (wr_stat && wdata[2]) begin
                ovr <= 1'b0;
            end
            // The return-to-idle cycle is still ST_TRAIL, so a write there
            // is treated as an overrun and never starts a new transfer.
            if (wr_tx && (state != ST_IDLE)) begin
                ovr <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (wr_tx) begin
                        shreg      <= wdata[7:0];
                        MOSI       <= wdata[7];
                        CSn        <= 1'b0;
                        busy       <= 1'b1;
                        clkdiv_lat <= clkdiv;
                        cnt        <= clkdiv;
                        state      <= ST_LEAD;
                    end
                end

                ST_LEAD: begin
                    if (cnt == 8'd0) begin
                        cnt     <= clkdiv_lat;
                        bit_cnt <= 3'd0;
                        state   <= ST_SHIFT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                ST_SHIFT: begin
                    if (cnt == 8'd0) begin
                        cnt <= clkdiv_lat;
                        if (!SCLK) begin
                            SCLK  <= 1'b1;
                            shreg <= {shreg[6:0], MISO};
                        end else begin
                            SCLK <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_TRAIL;
                            end else begin
                                // shreg[7] already holds the next TX bit
                                // because the rise shifted it up.
                                MOSI    <= shreg[7];
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                ST_TRAIL: begin
                    if (cnt == 8'd0) begin
                        state  <= ST_IDLE;
                        CSn    <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        rxdata <= shreg;
                        MOSI   <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_word = 16'd0;
        case (raddr[3:2])
            2'd0:    rd_word = {clkdiv, 7'd0, ie};
            2'd1:    rd_word = 16'd0;
            2'd2:    rd_word = {8'd0, rxdata};
            default: rd_word = {13'd0, ovr, done, busy};
        endcase
    end

    assign bus.RDATA_O = C_AXI_DATA_WIDTH'(rd_word);
    assign INT         = ie & done;

endmodule

// File: tb/tb_spi_master_core.sv
module tb_spi_master_core;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mosi, sclk, csn, irq, miso_w;
    logic miso_drv = 1'b0;
    logic loop_en = 1'b0;

    spi_master_core_if #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) bus ();

    assign miso_w = loop_en ? mosi : miso_drv;

    spi_master_core #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) dut (
        .AXI_ACLK   (clk),
        .AXI_ARESETN(rst_n),
        .bus        (bus),
        .MOSI       (mosi),
        .MISO       (miso_w),
        .SCLK       (sclk),
        .CSn        (csn),
        .INT        (irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model of the programmer-visible state
    logic       m_ie;
    logic [7:0] m_clkdiv;
    logic [7:0] m_rx;
    logic       m_done;
    logic       m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 1'b0; m_clkdiv = 8'd0; m_rx = 8'd0; m_done = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.WADDR_I = a; bus.WDATA_I = d; bus.WENA_I = 1'b1;
        @(posedge clk);
        #1 bus.WENA_I = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic rena, output logic [31:0] d);
        @(negedge clk);
        bus.RADDR_I = a; bus.RENA_I = rena;
        #1 d = bus.RDATA_O;
        @(posedge clk);
        #1 bus.RENA_I = 1'b0;
        if (rena && a[3:2] == 2'd2) m_done = 1'b0;
    endtask

    task automatic wr_m(input logic [3:0] a, input logic [31:0] d);
        wr(a, d);
        if (a[3:2] == 2'd0) begin
            m_ie = d[0]; m_clkdiv = d[15:8];
        end else if (a[3:2] == 2'd3) begin
            if (d[1]) m_done = 1'b0;
            if (d[2]) m_ovr = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        rd(4'h0, 1'b0, d); chk({tag, "_ctrl"}, d, {16'd0, m_clkdiv, 7'd0, m_ie});
        rd(4'h4, 1'b0, d); chk({tag, "_txdata"}, d, 32'd0);
        rd(4'h8, 1'b0, d); chk({tag, "_rxdata"}, d, {24'd0, m_rx});
        rd(4'hC, 1'b0, d); chk({tag, "_status"}, d, {29'd0, m_ovr, m_done, 1'b0});
        chk({tag, "_int"}, 32'(irq), 32'(m_ie & m_done));
    endtask

    // One full transfer observed cycle by cycle. Optionally injects one
    // register write in cycle inj_at (cycle 1 = first cycle with CSn low).
    task automatic xfer(input string tag, input logic [7:0] tx, input logic lp,
                        input logic [7:0] mb, input int inj_at,
                        input logic [3:0] inj_addr, input logic [31:0] inj_data);
        int h = int'(m_clkdiv) + 1;
        int lowcnt = 0, rises = 0, highcnt = 0, last_rise = 0, per_obs;
        logic [7:0] mcap = 8'd0;
        logic prev = 1'b0;
        logic ended = 1'b0;
        per_obs = 2 * h;
        @(negedge clk);
        loop_en = lp; miso_drv = mb[7];
        bus.WADDR_I = 4'h4; bus.WDATA_I = {24'd0, tx}; bus.WENA_I = 1'b1;
        for (int i = 1; i <= 18 * 256 + 20; i++) begin
            @(negedge clk);
            bus.WENA_I = 1'b0;
            if (csn) begin
                ended = 1'b1;
                break;
            end
            lowcnt++;
            if (sclk && !prev) begin
                rises++;
                mcap = {mcap[6:0], mosi};
                if (rises > 1 && (i - last_rise) != 2 * h) per_obs = i - last_rise;
                last_rise = i;
            end
            if (sclk) highcnt++;
            prev = sclk;
            if (rises < 8) miso_drv = mb[3'(7 - rises)];
            if (i == inj_at) begin
                bus.WADDR_I = inj_addr; bus.WDATA_I = inj_data; bus.WENA_I = 1'b1;
                if (inj_addr[3:2] == 2'd1) m_ovr = 1'b1;
                if (inj_addr[3:2] == 2'd3) begin
                    if (inj_data[1]) m_done = 1'b0;
                    if (inj_data[2]) m_ovr = 1'b0;
                end
            end
            if (inj_at > 0 && i == inj_at + 2) begin
                bus.RADDR_I = 4'hC;
                #1 chk({tag, "_mid_status"}, bus.RDATA_O, {29'd0, m_ovr, m_done, 1'b1});
            end
        end
        bus.WENA_I = 1'b0;
        chk({tag, "_end_seen"}, 32'(ended), 32'd1);
        chk({tag, "_csn_low"}, 32'(lowcnt), 32'(18 * h));
        chk({tag, "_sclk_rises"}, 32'(rises), 32'd8);
        chk({tag, "_sclk_high"}, 32'(highcnt), 32'(8 * h));
        chk({tag, "_sclk_period"}, 32'(per_obs), 32'(2 * h));
        chk({tag, "_mosi_bits"}, {24'd0, mcap}, {24'd0, tx});
        chk({tag, "_mosi_idle"}, 32'(mosi), 32'd0);
        m_done = 1'b1;
        m_rx = lp ? tx : mb;
        loop_en = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_csn_stays_high"}, 32'(csn), 32'd1);
        chk({tag, "_sclk_idle"}, 32'(sclk), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int h;
        bus.WDATA_I = '0; bus.WADDR_I = '0; bus.WENA_I = 1'b0;
        bus.RADDR_I = '0; bus.RENA_I = 1'b0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_csn", 32'(csn), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        check_regs("rst");

        // H=1 loopback
        wr_m(4'h0, 32'h0000_0001);
        xfer("a5", 8'hA5, 1'b1, 8'h00, 0, 4'h0, 32'h0);
        check_regs("a5");

        // RXDATA read clears DONE and drops INT
        rd(4'h8, 1'b1, d);
        chk("rx_read_val", d, 32'h0000_00A5);
        @(negedge clk);
        chk("rx_read_int", 32'(irq), 32'd0);
        check_regs("rx_clr");

        // H=4, MISO tied high, IE off
        wr_m(4'h0, 32'h0000_0300);
        xfer("3c", 8'h3C, 1'b0, 8'hFF, 0, 4'h0, 32'h0);
        check_regs("3c");

        // overrun during a busy transfer
        wr_m(4'hC, 32'h0000_0002);
        xfer("ovr", 8'h12, 1'b0, 8'($urandom), 10, 4'h4, 32'h0000_0034);
        check_regs("ovr");
        wr_m(4'hC, 32'h0000_0006);
        check_regs("ovr_clr");

        // DONE W1C in the end-of-transfer cycle: the set wins
        wr_m(4'h0, 32'h0000_0001);
        xfer("w1c_end", 8'h5A, 1'b1, 8'h00, 18, 4'hC, 32'h0000_0002);
        check_regs("w1c_end");

        // TXDATA write in the return-to-idle cycle is an overrun
        wr_m(4'hC, 32'h0000_0006);
        xfer("tx_end", 8'h81, 1'b1, 8'h00, 18, 4'h4, 32'h0000_0099);
        check_regs("tx_end");

        // randomized transfers
        for (int n = 0; n < 8; n++) begin
            logic [7:0] cd, tx, mb;
            logic ie, lp;
            int inj;
            cd = 8'($urandom_range(0, 3));
            ie = 1'($urandom_range(0, 1));
            tx = 8'($urandom);
            mb = 8'($urandom);
            lp = 1'($urandom_range(0, 1));
            wr_m(4'h0, {16'd0, cd, 7'd0, ie});
            h = int'(cd) + 1;
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 18 * h)) : 0;
            xfer("rnd", tx, lp, mb, inj, 4'h4, 32'($urandom));
            check_regs("rnd");
            if ($urandom_range(0, 1) == 1) rd(4'h8, 1'b1, d);
            else wr_m(4'hC, 32'h0000_0006);
            check_regs("rnd_clr");
        end

        // reset in the middle of SHIFT
        wr_m(4'h0, 32'h0000_0101);
        @(negedge clk);
        loop_en = 1'b1;
        bus.WADDR_I = 4'h4; bus.WDATA_I = 32'h0000_00FF; bus.WENA_I = 1'b1;
        @(negedge clk);
        bus.WENA_I = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_pre_csn", 32'(csn), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_csn", 32'(csn), 32'd1);
        chk("midrst_sclk", 32'(sclk), 32'd0);
        chk("midrst_mosi", 32'(mosi), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        loop_en = 1'b0;
        model_reset();
        check_regs("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
- Byte-wide SPI master core (mode 0: CPOL=0, CPHA=0, MSB first) placed behind axi_lite_slave_int inside axi_spi.
- Consumes the slave's simple register strobes (WDATA/WADDR/WENA, RADDR/RENA) and returns RDATA.
- Drives MOSI, SCLK and CSn, samples MISO, and raises a level interrupt on transfer completion.

Parameters:
- C_AXI_DATA_WIDTH, 32, register data width; only bits [15:0] are used, the rest read 0.
- C_AXI_ADDR_WIDTH, 4, byte address width; decode uses ADDR[3:2], ADDR[1:0] are ignored.

Ports:
- AXI_ACLK  in  1  core clock; all logic is on its rising edge.
- AXI_ARESETN  in  1  asynchronous, active-low reset.
- WDATA_I  in  C_AXI_DATA_WIDTH  write data from the register slave.
- WADDR_I  in  C_AXI_ADDR_WIDTH  write address.
- WENA_I  in  1  one-cycle write strobe; full-word write, no byte enables.
- RADDR_I  in  C_AXI_ADDR_WIDTH  read address.
- RENA_I  in  1  one-cycle read strobe; qualifies read side effects only.
- RDATA_O  out  C_AXI_DATA_WIDTH  combinational read mux of RADDR_I.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- SCLK  out  1  serial clock, idle low.
- CSn  out  1  chip select, active low.
- INT  out  1  level interrupt, equal to CTRL.IE & STATUS.DONE.

Behaviour:
- Reset state (async assert, sync release):
  - CSn=1, SCLK=0, MOSI=0, INT=0.
  - All registers 0; FSM in IDLE.
  - Reset mid-transfer aborts immediately: CSn rises and RXDATA is not updated.
- Register map:
  - 0x0 CTRL, RW: [0] IE, [15:8] CLKDIV.
  - 0x4 TXDATA, WO, reads 0: write [7:0]; starts a transfer when IDLE.
  - 0x8 RXDATA, RO: [7:0] last received byte. Read with RENA_I clears DONE. Writes ignored.
  - 0xC STATUS: [0] BUSY (RO), [1] DONE (sticky, W1C), [2] OVR (sticky, W1C).
- Half period: H = CLKDIV+1 clocks. CLKDIV is latched at transfer start; a CTRL write while BUSY affects the next transfer only.
- FSM states: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE. All outputs are registered.
- IDLE:
  - Write to TXDATA in cycle 0 loads the shift register.
  - Cycle 1: CSn=0, BUSY=1, MOSI=bit7; enter LEAD.
- LEAD: hold H cycles with SCLK=0.
- SHIFT: 16 half-periods of H cycles each.
  - Each SCLK rise: shift MISO into the shift-register LSB.
  - Each SCLK fall (except the 8th): MOSI takes the next bit.
  - After the 8th fall, enter TRAIL.
- TRAIL: hold H cycles with SCLK=0 and CSn=0.
- Transfer end, all in the same cycle:
  - CSn=1, BUSY=0, DONE=1.
  - RXDATA <= shift register; MOSI=0.
- Overall timing: CSn low for exactly 18H cycles; SCLK period 2H; 8 rising edges per transfer.
- OVR: a write to TXDATA while BUSY sets OVR; the data is discarded and the transfer in flight is unaffected.
- Simultaneous events:
  - DONE set at transfer end coinciding with an RXDATA read or a DONE W1C: the set wins.
  - TXDATA write in the same cycle the FSM returns to IDLE counts as BUSY and sets OVR.
  - TXDATA write while IDLE with DONE=1: starts normally; DONE is not auto-cleared.
- INT is combinational from registered IE and DONE; no extra latency beyond the flops.

Test Plan:
- Reset then read all four addresses -> RDATA 0; CSn=1, SCLK=0, MOSI=0, INT=0.
- CTRL=0x0001 (CLKDIV=0, IE=1); TXDATA=0xA5; MISO looped to MOSI:
  - CSn low 18 cycles; SCLK period 2 clocks; MOSI bits 1,0,1,0,0,1,0,1.
  - RXDATA=0xA5; STATUS=0x2; INT=1.
- Read RXDATA -> DONE=0, INT=0 on the next cycle. Then CTRL=0x0300 (H=4), TXDATA=0x3C, MISO tied 1:
  - CSn low 72 cycles; RXDATA=0xFF; INT stays 0 because IE=0.
- During a busy transfer of 0x12, write TXDATA=0x34:
  - STATUS reads 0x5 during the transfer; 0x12 is shifted out intact.
  - STATUS reads 0x6 at the end; writing STATUS=0x6 returns it to 0x0.
- Assert AXI_ARESETN low mid-SHIFT -> CSn=1, SCLK=0 immediately; after release STATUS=0 and RXDATA=0.
- Force a DONE W1C write in the exact end-of-transfer cycle -> DONE reads 1.
